// File: rtl/ct_spsram_banked_split.sv
// ---------------------------------------------------------------------------
// ct_spsram_banked_split
//
// Single-port SRAM wrapper that splits one logical array of 2**ADDR_WIDTH
// words into BANK_NUM physical banks. The top log2(BANK_NUM) address bits
// select the bank and the remaining low bits select the row inside it. Only
// the addressed bank is enabled on an access. Writes use a per-bit active-low
// mask. Reads take one cycle, or two with the optional output register.
//
// Parameters:
//   ADDR_WIDTH - logical address width (logical depth 2**ADDR_WIDTH)
//   DATA_WIDTH - data width, also the width of the bit write mask
//   BANK_NUM   - number of banks, power of two from 1 to 8
//   OUT_FLOP   - 0: read latency 1, 1: extra output register, latency 2
//
// Ports:
//   CLK  - clock, everything on the rising edge
//   RST  - synchronous active-high reset
//   A    - address
//   CEN  - chip enable, active low
//   GWEN - global write enable, active low (0 write, 1 read)
//   WEN  - bit write enable, active low (bit i written when WEN[i]=0)
//   D    - write data
//   Q    - read data, held until the next read result
//   BUSY - zero-initialisation sequencer active; accesses are ignored
//
// Build option:
//   CT_SPSRAM_INIT_CLEAR_EN - when defined, every reset starts a sequencer
//   that writes zero to every row of every bank before accepting accesses.
//   When undefined, BUSY is tied low and contents after reset are undefined.
// ---------------------------------------------------------------------------
module ct_spsram_banked_split #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_NUM   = 2,
  parameter int OUT_FLOP   = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY
);

  // Geometry. With a single bank there is no bank field, but a one-bit
  // select is kept so that every signal has a legal width.
  localparam int BANK_BITS = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 0;
  localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS      = 1 << ROW_W;

  logic [SEL_W-1:0]      bank_sel;
  logic [ROW_W-1:0]      row_sel;
  logic                  busy;
  logic                  access;
  logic                  rd_access;
  logic [BANK_NUM-1:0]   bank_en;
  logic                  init_we;
  logic [ROW_W-1:0]      init_row;
  logic [DATA_WIDTH-1:0] bank_q [BANK_NUM];
  logic [DATA_WIDTH-1:0] q_mux;

  // Address split into bank select and row.
  generate
    if (BANK_BITS > 0) begin : g_bank_field
      assign bank_sel = A[ADDR_WIDTH-1 -: BANK_BITS];
    end else begin : g_single_bank
      assign bank_sel = '0;
    end
  endgenerate

  assign row_sel = A[ROW_W-1:0];

`ifdef CT_SPSRAM_INIT_CLEAR_EN
  // Zero-initialisation sequencer. Reset parks it in INIT with the row
  // counter at 0; each non-reset cycle in INIT clears one row in all banks
  // at once. The cycle that clears the last row also moves to READY, so
  // BUSY drops on the edge right after the final row is written.
  typedef enum logic {
    INIT,
    READY
  } init_state_t;

  init_state_t      state;
  logic [ROW_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == ROW_W'(ROWS - 1)) begin
        state <= READY;
      end
    end
  end

  assign busy     = (state == INIT);
  assign init_we  = (state == INIT) && !RST;
  assign init_row = cnt;
`else
  assign busy     = 1'b0;
  assign init_we  = 1'b0;
  assign init_row = '0;
`endif

  assign BUSY = busy;

  // Requests are honoured only outside reset and outside initialisation;
  // anything else is simply dropped.
  assign access    = !CEN && !busy && !RST;
  assign rd_access = access && GWEN;

  // One-hot bank enable for the addressed bank only.
  always_comb begin
    bank_en = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_en[b] = access && (bank_sel == SEL_W'(b));
    end
  end

  // Physical banks. Each bank owns its array and a read register that only
  // changes on a read to that bank, so the output mux keeps presenting the
  // last read word across idle and write cycles.
  generate
    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [ROWS];
      logic [DATA_WIDTH-1:0] dout;
      logic                  bank_wr;
      logic                  bank_rd;

      assign bank_wr = bank_en[b] && !GWEN;
      assign bank_rd = bank_en[b] && GWEN;

      // Array write port. Initialisation and normal writes never overlap
      // because accesses are blocked while the sequencer runs.
      always_ff @(posedge CLK) begin
        if (init_we) begin
          mem[init_row] <= '0;
        end else if (bank_wr) begin
          mem[row_sel] <= (mem[row_sel] & WEN) | (D & ~WEN);
        end
      end

      // Read register; cleared on reset so Q reads zero after reset.
      always_ff @(posedge CLK) begin
        if (RST) begin
          dout <= '0;
        end else if (bank_rd) begin
          dout <= mem[row_sel];
        end
      end

      assign bank_q[b] = dout;
    end
  endgenerate

  // The bank index of each read travels with it so the output mux picks the
  // bank that actually served the most recent read.
  generate
    if (BANK_BITS > 0) begin : g_rd_bank
      logic [SEL_W-1:0] rd_bank;

      always_ff @(posedge CLK) begin
        if (RST) begin
          rd_bank <= '0;
        end else if (rd_access) begin
          rd_bank <= bank_sel;
        end
      end

      assign q_mux = bank_q[rd_bank];
    end else begin : g_rd_single
      assign q_mux = bank_q[0];
    end
  endgenerate

  // Optional output register. A read issued in one cycle becomes visible on
  // the mux in the next and is captured here at the end of that cycle. A
  // reset clears the pending flag so an in-flight read is discarded.
  generate
    if (OUT_FLOP != 0) begin : g_out_flop
      logic                  rd_pending;
      logic [DATA_WIDTH-1:0] q_flop;

      always_ff @(posedge CLK) begin
        if (RST) begin
          rd_pending <= 1'b0;
          q_flop     <= '0;
        end else begin
          rd_pending <= rd_access;
          if (rd_pending) begin
            q_flop <= q_mux;
          end
        end
      end

      assign Q = q_flop;
    end else begin : g_no_out_flop
      assign Q = q_mux;
    end
  endgenerate

endmodule

// File: tb/tb_ct_spsram_banked_split.sv
// ---------------------------------------------------------------------------
// tb_ct_spsram_banked_split
//
// Drives two instances of the banked SRAM wrapper from one stimulus stream:
// the default geometry (2048x32, 2 banks, latency 1) and a 1024x32 array in
// 4 banks with the output register (latency 2). A word-array model tracks
// the logical contents and which bits are known, and expected read data is
// taken from that model with the matching read latency.
// ---------------------------------------------------------------------------
module tb_ct_spsram_banked_split;

`ifdef CT_SPSRAM_INIT_CLEAR_EN
  localparam int EXP_ROWS1 = 1024;
  localparam int EXP_ROWS4 = 256;
  localparam logic [31:0] EXP_BUSY = 32'h3;
`else
  localparam int EXP_ROWS1 = 0;
  localparam int EXP_ROWS4 = 0;
  localparam logic [31:0] EXP_BUSY = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] a;
  logic [9:0]  a4;
  logic        cen;
  logic        gwen;
  logic [31:0] wen;
  logic [31:0] d;
  logic [31:0] q1;
  logic [31:0] q4;
  logic        busy1;
  logic        busy4;

  always #5 clk = ~clk;

  ct_spsram_banked_split #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .BANK_NUM(2), .OUT_FLOP(0)
  ) dut (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen), .D(d), .Q(q1), .BUSY(busy1)
  );

  ct_spsram_banked_split #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .BANK_NUM(4), .OUT_FLOP(1)
  ) dut4 (
    .CLK(clk), .RST(rst), .A(a4), .CEN(cen), .GWEN(gwen),
    .WEN(wen), .D(d), .Q(q4), .BUSY(busy4)
  );

  // Reference model: logical words plus a mask of bits with defined values.
  logic [31:0] mem1 [2048];
  logic [31:0] kn1  [2048];
  logic [31:0] mem4 [1024];
  logic [31:0] kn4  [1024];
  logic [31:0] exp1, k1, exp4, k4, pipe4, pipek4;
  bit          pipev4;

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = '0;
      kn1[i]  = '1;
    end
    for (int i = 0; i < 1024; i++) begin
      mem4[i] = '0;
      kn4[i]  = '1;
    end
  endtask

  // One bus cycle on both DUTs, with model update and output checks.
  task automatic applyStimulus(input bit c, input bit g, input logic [10:0] ad,
                               input logic [9:0] ad4, input logic [31:0] w,
                               input logic [31:0] dd);
    logic [31:0] r1, rk1, r4, rk4;
    cen = c; gwen = g; a = ad; a4 = ad4; wen = w; d = dd;
    #1;
    checkOutput("bank_en2", {30'b0, dut.bank_en}, c ? 32'h0 : (32'h1 << ad[10]));
    checkOutput("bank_en4", {28'b0, dut4.bank_en}, c ? 32'h0 : (32'h1 << ad4[9:8]));
    r1 = mem1[ad]; rk1 = kn1[ad];
    r4 = mem4[ad4]; rk4 = kn4[ad4];
    if (!c && !g) begin
      mem1[ad]  = (mem1[ad] & w) | (dd & ~w);
      kn1[ad]   = kn1[ad] | ~w;
      mem4[ad4] = (mem4[ad4] & w) | (dd & ~w);
      kn4[ad4]  = kn4[ad4] | ~w;
    end
    @(posedge clk);
    #1;
    if (!c && g) begin
      exp1 = r1;
      k1   = rk1;
    end
    if (pipev4) begin
      exp4 = pipe4;
      k4   = pipek4;
    end
    pipev4 = !c && g;
    pipe4  = r4;
    pipek4 = rk4;
    checkOutput("q_lat1", q1 & k1, exp1 & k1);
    checkOutput("q_lat2", q4 & k4, exp4 & k4);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b1, 11'h0, 10'h0, '1, '0);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    cen = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    exp1 = '0; k1 = '1; exp4 = '0; k4 = '1; pipev4 = 1'b0;
    checkOutput("rst_q1", q1, 32'h0);
    checkOutput("rst_q4", q4, 32'h0);
    checkOutput("rst_busy", {30'b0, busy1, busy4}, EXP_BUSY);
`ifdef CT_SPSRAM_INIT_CLEAR_EN
    modelClear();
`endif
    rst = 1'b0;
  endtask

  // Counts edges until BUSY falls on each DUT; a request issued at step 200
  // falls inside initialisation and must be dropped.
  task automatic waitInit();
    int n1 = -1;
    int n4 = -1;
    for (int k = 0; k < 5000; k++) begin
      if (!busy1 && n1 < 0) n1 = k;
      if (!busy4 && n4 < 0) n4 = k;
      if (n1 >= 0 && n4 >= 0) break;
      if (k == 200) begin
        cen = 1'b0; gwen = 1'b0; a = 11'h005; a4 = 10'h005; wen = '0; d = '1;
      end else begin
        cen = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    cen = 1'b1;
    checkOutput("busy_cycles1", 32'(n1), 32'(EXP_ROWS1));
    checkOutput("busy_cycles4", 32'(n4), 32'(EXP_ROWS4));
  endtask

  initial begin
    logic [31:0] obs [6];
    logic [31:0] holdv;
    rst = 1'b0; cen = 1'b1; gwen = 1'b1; a = '0; a4 = '0; wen = '1; d = '0;
    exp1 = '0; k1 = '0; exp4 = '0; k4 = '0; pipe4 = '0; pipek4 = '0; pipev4 = 1'b0;
    for (int i = 0; i < 2048; i++) begin mem1[i] = '0; kn1[i] = '0; end
    for (int i = 0; i < 1024; i++) begin mem4[i] = '0; kn4[i] = '0; end

    doReset(2);
    waitInit();

`ifdef CT_SPSRAM_INIT_CLEAR_EN
    applyStimulus(1'b0, 1'b1, 11'h000, 10'h000, '1, '0);
    checkOutput("init_sweep_000", q1, 32'h0);
    applyStimulus(1'b0, 1'b1, 11'h3FF, 10'h3FF, '1, '0);
    checkOutput("init_sweep_3ff", q1, 32'h0);
    applyStimulus(1'b0, 1'b1, 11'h400, 10'h005, '1, '0);
    checkOutput("init_sweep_400", q1, 32'h0);
    applyStimulus(1'b0, 1'b1, 11'h7FF, 10'h2FF, '1, '0);
    checkOutput("init_sweep_7ff", q1, 32'h0);
    checkOutput("init_sweep_005_l2", q4, 32'h0);
`else
    applyStimulus(1'b0, 1'b0, 11'h7AB, 10'h1AB, 32'h0, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 11'h7AB, 10'h1AB, '1, '0);
    checkOutput("macro_off_wr_rd", q1, 32'hCAFEF00D);
`endif

    // Masked write
    applyStimulus(1'b0, 1'b0, 11'h123, 10'h123, 32'h0, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 11'h123, 10'h123, 32'hFFFF0000, 32'h0000FFFF);
    applyStimulus(1'b0, 1'b1, 11'h123, 10'h123, '1, '0);
    checkOutput("masked_write", q1, 32'hDEADFFFF);
    idle();
    checkOutput("masked_write_l2", q4, 32'hDEADFFFF);

    // Bank interleave on the 4-bank, latency-2 instance
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 11'(i * 256), 10'(i * 256), 32'h0, 32'(i + 1));
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) applyStimulus(1'b0, 1'b1, 11'(i * 256), 10'(i * 256), '1, '0);
      else idle();
      obs[i] = q4;
    end
    for (int i = 1; i < 5; i++) begin
      checkOutput($sformatf("interleave_%0d", i), obs[i], 32'(i));
    end

    // Q hold across idle and write cycles
    holdv = $urandom;
    applyStimulus(1'b0, 1'b0, 11'h005, 10'h005, 32'h0, holdv);
    applyStimulus(1'b0, 1'b1, 11'h005, 10'h005, '1, '0);
    checkOutput("hold_read", q1, holdv);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("hold_idle", q1, holdv);
      checkOutput("hold_idle_l2", q4, holdv);
    end
    applyStimulus(1'b0, 1'b0, 11'h005, 10'h005, 32'h0, ~holdv);
    checkOutput("hold_write", q1, holdv);
    checkOutput("hold_write_l2", q4, holdv);
    applyStimulus(1'b0, 1'b1, 11'h005, 10'h005, '1, '0);
    checkOutput("hold_reread", q1, ~holdv);

    // Reset while a latency-2 read is in flight
    applyStimulus(1'b0, 1'b1, 11'h123, 10'h123, '1, '0);
    doReset(1);
    idle();
    checkOutput("rst_mid_read_l2", q4, 32'h0);

`ifdef CT_SPSRAM_INIT_CLEAR_EN
    // Reset in the middle of initialisation restarts the full sweep
    for (int i = 0; i < 498; i++) begin
      @(posedge clk);
    end
    #1;
    doReset(1);
    waitInit();
    applyStimulus(1'b0, 1'b1, 11'h005, 10'h005, '1, '0);
    checkOutput("dropped_write", q1, 32'h0);
    applyStimulus(1'b0, 1'b1, 11'h123, 10'h123, '1, '0);
    checkOutput("reinit_clear", q1, 32'h0);
    checkOutput("dropped_write_l2", q4, 32'h0);
`endif

    // Randomized traffic over a small address pool in every bank
    for (int i = 0; i < 1500; i++) begin
      logic [10:0] ra;
      logic [9:0]  ra4;
      logic [31:0] rw;
      int          sel;
      ra  = {1'($urandom), 6'd0, 4'($urandom)};
      ra4 = {2'($urandom), 4'd0, 4'($urandom)};
      sel = $urandom_range(0, 2);
      rw  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom) : 32'hFFFFFFFF;
      applyStimulus($urandom_range(0, 3) == 0, 1'($urandom), ra, ra4, rw, 32'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
